bcd_countdown: RTL and testbench
================================

# bcd_countdown

Six-digit BCD countdown timer: the down-counting counterpart of the stopwatch up-counter, sharing its digit format (units through hundred-thousands, 4-bit BCD each). It loads a preset, decrements once per prescaled tick while running, and pulses `done` on reaching zero. It sits beside the stopwatch counter and drives the same display path.

## Interface
- `TICK_DIV`, default 4: clock cycles per decrement while running; legal range ≥ 1.
- `clk`  in  1  system clock, all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load`  in  1  loads `load_val` this cycle.
- `load_val`  in  24  preset value: six BCD digits, [3:0] units … [23:20] hundred-thousands.
- `start`  in  1  start or resume counting.
- `stop`  in  1  pause counting.
- `d0`..`d5`  out  4 each  current BCD digits, d0 units, d5 hundred-thousands.
- `running`  out  1  high while the state is RUN.
- `done`  out  1  one-cycle pulse when the count reaches zero.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset: IDLE, all digits 0, prescaler 0, `running`=0, `done`=0, reload register 0.
- Input priority each cycle: `load` > `stop` > `start`.
- `load`, in any state: digits ← `load_val`, reload register ← `load_val`, prescaler ← 0, state → IDLE.
- `start` in IDLE or PAUSE with a nonzero value: state → RUN. With the value all zero, `start` is ignored.
- `stop` in RUN: state → PAUSE; the prescaler and digits hold.
- `start` and `stop` asserted together: `stop` wins. In IDLE, PAUSE or DONE this means no state change.
- Prescaler: counts 0..TICK_DIV-1 only in RUN. A tick occurs when it equals TICK_DIV-1; the prescaler then wraps to 0.
- Decrement on tick, as a borrow chain:
  - d0 always takes a borrow.
  - Digit i takes a borrow only if digits 0..i-1 are all 0.
  - A digit taking a borrow goes to digit−1, or from 0 to 9.
- Zero detect: a tick with the value equal to 000001 makes the value 000000. In that same update `done` ← 1 for exactly one cycle and state → DONE, unless the configuration macro below says otherwise.
- DONE: digits hold at 0. `start` is ignored. `load` exits to IDLE.
- Load values containing non-BCD nibbles (A–F) are accepted unchanged. Decrement behaviour on them is unspecified; the caller must not supply them.

## Timing
- All outputs are registered. `running` reflects the current state with no extra delay.
- `start` sampled at edge N: RUN is in effect from N. The first tick occurs TICK_DIV cycles later, so the first digit change is visible after edge N+TICK_DIV.
- Load value V with no pauses: `done` goes high V×TICK_DIV cycles after RUN is entered, coincident with the digits first reading 000000.
- Pause and resume: the prescaler phase is preserved, so total run cycles to `done` are unchanged.
- Asynchronous reset mid-count forces all reset values immediately, including clearing a pending `done`.
- TICK_DIV=1: decrement every RUN cycle; the prescaler logic collapses to a constant tick.
- Wrap example: 010000 → 009999 on one tick.

## Configuration
- `BCD_COUNTDOWN_AUTORELOAD_EN` defined:
  - On the zero-reaching tick, `done` pulses and the digits ← reload register instead of 0.
  - State stays RUN, periodic mode; DONE is unreachable.
  - If the reload register is 0, the zero-reaching tick cannot occur.
- `BCD_COUNTDOWN_AUTORELOAD_EN` undefined: one-shot behaviour as described in Operation.

## Test plan
- Reset, TICK_DIV=4: hold `rst`=0, then release → digits 000000, `running`=0, `done`=0. Then `start` → stays IDLE.
- Load 000003, `start` → digits 000002, 000001, 000000 at 4, 8 and 12 cycles after start. `done` is high only in cycle 12. State DONE, `running`=0.
- Load 010000, run one tick → digits 009999. Load 100000, run one tick → 099999.
- Load 000005 and start; `stop` after 6 cycles and hold 10 cycles → digits frozen at 000004. `start` → `done` at 20 total RUN cycles.
- Same-cycle `start`+`stop` in PAUSE → remains PAUSE. `load` 000007 during RUN → IDLE, digits 000007, prescaler 0.
- With `BCD_COUNTDOWN_AUTORELOAD_EN`, load 000002, start, TICK_DIV=4:
  - `done` pulses at cycles 8 and 16.
  - Digits read 000002 after each pulse; `running` stays 1.

Source files
------------

// File: rtl/bcd_countdown.sv
// Six-digit BCD countdown timer: loads a preset and decrements once per TICK_DIV run cycles.
// Latency: all outputs registered; a start sampled at edge N gives the first digit change after edge N+TICK_DIV.
// Backpressure: none; control inputs are sampled every cycle with priority load > stop > start.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   load/load_val  load six BCD digits ([3:0] units .. [23:20] hundred-thousands) and the reload register
//   start/stop     start or resume / pause counting
//   d0..d5         current digits, d0 units .. d5 hundred-thousands
//   running        high while in RUN
//   done           one-cycle pulse on the tick that reaches zero
//
// Optional feature: define BCD_COUNTDOWN_AUTORELOAD_EN for periodic mode. In that mode the
// zero-reaching tick reloads the preset and the timer keeps running.
module bcd_countdown #(
    parameter int TICK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [23:0] load_val,
    input  logic        start,
    input  logic        stop,
    output logic [3:0]  d0,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic [3:0]  d4,
    output logic [3:0]  d5,
    output logic        running,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    // A single prescaler bit is kept even for TICK_DIV=1; it stays at 0,
    // so the tick compare is always true and the counter folds away.
    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_t        state_q, state_d;
    logic [23:0]   digits_q, digits_d;
    logic [23:0]   reload_q, reload_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic          tick;

    // Borrow ripples upward through digits that are 0; each such digit wraps to 9.
    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick = (state_q == RUN) && (presc_q == PRESC_MAX);

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        done_d   = 1'b0;

        if (load) begin
            digits_d = load_val;
            reload_d = load_val;
            presc_d  = '0;
            state_d  = IDLE;
        end else if (state_q == RUN) begin
            if (stop) begin
                // Prescaler and digits hold so the run phase resumes exactly.
                state_d = PAUSE;
            end else if (tick) begin
                presc_d = '0;
                if (digits_q == 24'h000001) begin
                    done_d = 1'b1;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
                    digits_d = reload_q;
`else
                    digits_d = 24'h000000;
                    state_d  = DONE;
`endif
                end else begin
                    digits_d = bcd_dec(digits_q);
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end else if (!stop && start) begin
            // A stop asserted alongside start blocks it; a zero value cannot be started.
            if ((state_q == IDLE || state_q == PAUSE) && digits_q != 24'h000000) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            digits_q <= 24'h000000;
            reload_q <= 24'h000000;
            presc_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            done_q   <= done_d;
        end
    end

    assign d0      = digits_q[3:0];
    assign d1      = digits_q[7:4];
    assign d2      = digits_q[11:8];
    assign d3      = digits_q[15:12];
    assign d4      = digits_q[19:16];
    assign d5      = digits_q[23:20];
    assign running = (state_q == RUN);
    assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Testbench for bcd_countdown with TICK_DIV=4.
// Latency: one vector per clock; outputs sampled 1 time unit after the rising edge.
// Backpressure: not applicable.
module tb_bcd_countdown;

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        load;
    logic [23:0] load_val;
    logic        start;
    logic        stop;
    logic [3:0]  d0, d1, d2, d3, d4, d5;
    logic        running;
    logic        done;
    logic [23:0] digits;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        l;
        logic [23:0] lv;
        logic        st;
        logic        sp;
        logic [23:0] ed;
        logic        er;
        logic        edn;
    } vec_t;

    vec_t vecs[$];

    bcd_countdown #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .d4       (d4),
        .d5       (d5),
        .running  (running),
        .done     (done)
    );

    assign digits = {d5, d4, d3, d2, d1, d0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic add(input int n, input logic l, input logic [23:0] lv, input logic st,
                       input logic sp, input logic [23:0] ed, input logic er, input logic edn);
        vec_t v;
        v.l = l; v.lv = lv; v.st = st; v.sp = sp; v.ed = ed; v.er = er; v.edn = edn;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic drive(input logic l, input logic [23:0] lv, input logic st, input logic sp);
        load = l; load_val = lv; start = st; stop = sp;
    endtask

    initial begin
        int done_k;
        rst = 1'b0;
        drive(1'b0, 24'h0, 1'b0, 1'b0);

        // Reset state
        step(); step();
        chk("reset_digits", {8'h0, digits}, 32'h0);
        chk("reset_running", {31'h0, running}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        rst = 1'b1;
        step();
        chk("post_reset_digits", {8'h0, digits}, 32'h0);

        // Start with a zero value is ignored; count 3 to zero; wraps; load during RUN
        add(1, 0, 24'h0, 1, 0, 24'h000000, 0, 0);
        add(1, 1, 24'h000003, 0, 0, 24'h000003, 0, 0);
        add(1, 0, 24'h0, 1, 0, 24'h000003, 1, 0);
        add(3, 0, 24'h0, 0, 0, 24'h000003, 1, 0);
        add(1, 0, 24'h0, 0, 0, 24'h000002, 1, 0);
        add(3, 0, 24'h0, 0, 0, 24'h000002, 1, 0);
        add(1, 0, 24'h0, 0, 0, 24'h000001, 1, 0);
        add(3, 0, 24'h0, 0, 0, 24'h000001, 1, 0);
        add(1, 0, 24'h0, 0, 0, AR ? 24'h000003 : 24'h0, AR, 1);
        add(1, 0, 24'h0, 0, 0, AR ? 24'h000003 : 24'h0, AR, 0);
        add(1, 0, 24'h0, 1, 0, AR ? 24'h000003 : 24'h0, AR, 0);
        add(1, 1, 24'h010000, 0, 0, 24'h010000, 0, 0);
        add(1, 0, 24'h0, 1, 0, 24'h010000, 1, 0);
        add(3, 0, 24'h0, 0, 0, 24'h010000, 1, 0);
        add(1, 0, 24'h0, 0, 0, 24'h009999, 1, 0);
        add(1, 1, 24'h100000, 0, 0, 24'h100000, 0, 0);
        add(1, 0, 24'h0, 1, 0, 24'h100000, 1, 0);
        add(3, 0, 24'h0, 0, 0, 24'h100000, 1, 0);
        add(1, 0, 24'h0, 0, 0, 24'h099999, 1, 0);
        add(2, 0, 24'h0, 0, 0, 24'h099999, 1, 0);
        add(1, 1, 24'h000007, 0, 0, 24'h000007, 0, 0);
        add(1, 0, 24'h0, 1, 0, 24'h000007, 1, 0);
        add(3, 0, 24'h0, 0, 0, 24'h000007, 1, 0);
        add(1, 0, 24'h0, 0, 0, 24'h000006, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].l, vecs[i].lv, vecs[i].st, vecs[i].sp);
            step();
            chk($sformatf("vec%0d_digits", i), {8'h0, digits}, {8'h0, vecs[i].ed});
            chk($sformatf("vec%0d_running", i), {31'h0, running}, {31'h0, vecs[i].er});
            chk($sformatf("vec%0d_done", i), {31'h0, done}, {31'h0, vecs[i].edn});
        end

        // Pause and resume: prescaler phase preserved, 20 run cycles to done
        drive(1, 24'h000005, 0, 0); step();
        drive(0, 24'h0, 1, 0); step();
        drive(0, 24'h0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        chk("pause_pre_digits", {8'h0, digits}, 32'h4);
        drive(0, 24'h0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pause_hold_digits", {8'h0, digits}, 32'h4);
            chk("pause_hold_running", {31'h0, running}, 32'h0);
        end
        drive(0, 24'h0, 1, 1); step();
        chk("pause_startstop_running", {31'h0, running}, 32'h0);
        chk("pause_startstop_digits", {8'h0, digits}, 32'h4);
        drive(0, 24'h0, 1, 0); step();
        chk("resume_running", {31'h0, running}, 32'h1);
        drive(0, 24'h0, 0, 0);
        done_k = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 2) chk("resume_phase_k2", {8'h0, digits}, 32'h4);
            if (k == 3) chk("resume_phase_k3", {8'h0, digits}, 32'h3);
            if (done) begin
                done_k = k;
                break;
            end
        end
        chk("resume_done_cycle", done_k, 32'd15);
        chk("resume_done_digits", {8'h0, digits}, AR ? 32'h5 : 32'h0);
        chk("resume_done_running", {31'h0, running}, {31'h0, AR});

        // Asynchronous reset clears a pending done immediately
        drive(1, 24'h000001, 0, 0); step();
        drive(0, 24'h0, 1, 0); step();
        drive(0, 24'h0, 0, 0);
        for (int i = 0; i < 4; i++) step();
        chk("arst_pre_done", {31'h0, done}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("arst_done", {31'h0, done}, 32'h0);
        chk("arst_digits", {8'h0, digits}, 32'h0);
        chk("arst_running", {31'h0, running}, 32'h0);
        step();
        rst = 1'b1;
        step();

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
        // Periodic mode: done at cycles 8 and 16, reloaded digits, stays running
        drive(1, 24'h000002, 0, 0); step();
        drive(0, 24'h0, 1, 0); step();
        drive(0, 24'h0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("ar_done_k%0d", k), {31'h0, done}, {31'h0, (k == 8 || k == 16)});
            chk($sformatf("ar_running_k%0d", k), {31'h0, running}, 32'h1);
            if (k == 8 || k == 16) chk($sformatf("ar_digits_k%0d", k), {8'h0, digits}, 32'h2);
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
